cpu_sram_bridge: RTL and testbench
==================================

Name: cpu_sram_bridge

Overview:
- Sits between the five-stage core's instruction/data memory ports and the single shared memory port.
- Both sides use the SRAM-like request handshake: req/addr_ok for requests, data_ok for responses.
- Arbitrates the two core request channels onto one downstream port and tracks outstanding transactions in order.
- Returns each read response to the channel that issued it.

Parameters:
OUTSTANDING, 2, max accepted-but-unanswered downstream transactions (1..8)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
inst_req  in  1  instruction channel request valid
inst_wr  in  1  1=write (core drives 0)
inst_size  in  2  0=byte, 1=half, 2=word
inst_addr  in  32  byte address
inst_wstrb  in  4  byte write strobes
inst_wdata  in  32  write data
inst_addr_ok  out  1  inst request accepted this cycle
inst_data_ok  out  1  inst response valid this cycle
inst_rdata  out  32  inst response data
data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata  in  1/1/2/32/4/32  data channel, same meaning as inst_*
data_addr_ok  out  1  data request accepted this cycle
data_data_ok  out  1  data response valid this cycle (reads and write acks)
data_rdata  out  32  data response data
mem_req  out  1  downstream request valid
mem_wr  out  1  downstream write
mem_size  out  2  downstream size
mem_addr  out  32  downstream address
mem_wstrb  out  4  downstream strobes
mem_wdata  out  32  downstream write data
mem_addr_ok  in  1  downstream accepted request
mem_data_ok  in  1  downstream response valid (strictly in order)
mem_rdata  in  32  downstream response data

Behaviour:
- Clock and reset: single clock clk. reset is asynchronous and active-high. All state clears immediately on reset assertion.
- Reset values: tag FIFO empty, count=0, lock_valid=0, rr pointer=inst.
  - mem_req, all addr_ok outputs and all data_ok outputs are 0 while reset is asserted.
- Arbitration:
  - full = (count == OUTSTANDING), taken from the registered count.
  - When lock_valid=1: sel = lock_src.
  - Otherwise: sel = data if data_req, else inst (fixed data priority).
  - mem_req = (req of sel) & ~full & ~reset.
  - mem_* fields are muxed combinationally from sel.
- Acceptance: mem_req & mem_addr_ok -> pulse <sel>_addr_ok in the same cycle. The unselected channel's addr_ok is 0.
- Lock:
  - mem_req=1 & mem_addr_ok=0 -> next cycle lock_valid=1, lock_src=sel. The request stays stable until accepted, even if the other channel raises req.
  - Lock clears on the accepting cycle.
  - A locked channel dropping req is a core protocol violation. The lock still holds until acceptance.
- Tag FIFO:
  - Depth OUTSTANDING, one bit per entry (0=inst, 1=data).
  - Push sel on acceptance. Pop on mem_data_ok when count>0.
  - Push and pop in the same cycle leaves count unchanged and pointers both advance.
  - When full, no push, even if a pop occurs that cycle; the new request is accepted the next cycle at earliest.
  - Pointers wrap modulo OUTSTANDING.
  - count width covers 0..OUTSTANDING.
- Response routing:
  - inst_data_ok = mem_data_ok & count>0 & head==0.
  - data_data_ok = mem_data_ok & count>0 & head==1.
  - inst_rdata = data_rdata = mem_rdata (pass-through, zero latency).
- Spurious response: mem_data_ok while count=0 is ignored. No pop, no data_ok.
- Reset mid-operation: FIFO and lock are discarded. Responses for transactions accepted before reset are dropped, because count=0.
- Latency: 0 added cycles on both the request and response paths. Throughput is 1 request/cycle while not full.

Optional Feature:
- Macro: BRIDGE_RR_ARB_EN.
- Defined: when both channels request and lock_valid=0, grant goes to the channel opposite rr_last. rr_last updates to the granted source on each acceptance. rr_last resets to inst, so data wins the first conflict.
- Undefined: fixed data priority as above. rr_last is absent.

Test Plan:
1. Data read only: data_req=1, addr=0x1c000100, size=2; mem_addr_ok=1 at cycle 0; mem_data_ok=1, rdata=0xDEADBEEF at cycle 2 -> data_addr_ok=1 at cycle 0, data_data_ok=1 with data_rdata=0xDEADBEEF at cycle 2, inst_data_ok stays 0.
2. Both channels request together, mem_addr_ok=1: inst addr 0x1c000000, data addr 0x00001000 -> data accepted in cycle 0 and inst in cycle 1. Responses 0x11 then 0x22 route to data then inst. With BRIDGE_RR_ARB_EN, a second conflict grants inst first.
3. Lock: inst_req=1, mem_addr_ok=0 for 3 cycles, data_req rises at cycle 1 -> mem_addr stays 0x1c000000 through cycle 3. When mem_addr_ok rises in cycle 3, inst_addr_ok=1; data is accepted in cycle 4.
4. Full (OUTSTANDING=2): two accepted inst reads, no responses -> mem_req=0 with inst_req=1. mem_data_ok in cycle k -> mem_req=1 again in cycle k+1, count stays 2 after that acceptance.
5. Spurious response: mem_data_ok=1 with count=0 -> both data_ok=0, count remains 0.
6. Reset mid-flight: one accepted data read, then reset pulse, then mem_data_ok -> data_data_ok=0, and mem_req=0 during reset.

Source files
------------

// File: rtl/cpu_sram_bridge_if.sv
// rtl/cpu_sram_bridge_if.sv - SRAM-like request/response channel bundle
//
// One channel of the SRAM-like handshake: a request (req/wr/size/addr/
// wstrb/wdata) accepted by addr_ok, and a response (data_ok/rdata).
//   master : drives the request fields, receives addr_ok/data_ok/rdata
//   slave  : receives the request fields, drives addr_ok/data_ok/rdata
interface cpu_sram_bridge_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wstrb, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wstrb, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/cpu_sram_bridge.sv
// rtl/cpu_sram_bridge.sv - arbitrates core inst/data channels onto one memory port
//
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; clears FIFO, count, lock
//   inst  : instruction channel from the core (slave side)
//   data  : data channel from the core (slave side)
//   mem   : shared downstream memory port (master side)
// Parameters:
//   OUTSTANDING : accepted-but-unanswered downstream transactions (1..8)
// Optional feature:
//   BRIDGE_RR_ARB_EN : round-robin grant on simultaneous requests instead
//                      of fixed data priority.
module cpu_sram_bridge #(
  parameter int OUTSTANDING = 2
) (
  input logic              clk,
  input logic              reset,
  cpu_sram_bridge_if.slave  inst,
  cpu_sram_bridge_if.slave  data,
  cpu_sram_bridge_if.master mem
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {ST_OPEN, ST_LOCKED} lock_state_e;

  lock_state_e state_q, state_d;
  logic        lock_src_q, lock_src_d;
  logic        lock_valid;

  logic        sel;        // 0 = inst, 1 = data
  logic        sel_req;
  logic        full;
  logic        accept;
  logic        pop;
  logic        head;

  logic [CW-1:0]          count_q;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [OUTSTANDING-1:0] tag_q;

`ifdef BRIDGE_RR_ARB_EN
  logic rr_last_q;
`endif

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // Lock FSM: a request presented but not accepted must stay on the bus
  // until the downstream port takes it, whatever the other channel does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_OPEN;
      lock_src_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_src_q <= lock_src_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_src_d = lock_src_q;
    case (state_q)
      ST_OPEN: begin
        if (mem.req && !mem.addr_ok) begin
          state_d    = ST_LOCKED;
          lock_src_d = sel;
        end
      end
      ST_LOCKED: begin
        if (accept) state_d = ST_OPEN;
      end
      default: state_d = ST_OPEN;
    endcase
  end

  always_comb begin
    lock_valid = (state_q == ST_LOCKED);
  end

  // Source selection
  always_comb begin
    if (lock_valid) begin
      sel = lock_src_q;
`ifdef BRIDGE_RR_ARB_EN
    end else if (inst.req && data.req) begin
      sel = ~rr_last_q;
`endif
    end else begin
      sel = data.req;
    end
  end

  assign full    = (count_q == CW'(OUTSTANDING));
  assign sel_req = sel ? data.req : inst.req;
  assign accept  = mem.req & mem.addr_ok;

  assign mem.req   = sel_req & ~full & ~reset;
  assign mem.wr    = sel ? data.wr    : inst.wr;
  assign mem.size  = sel ? data.size  : inst.size;
  assign mem.addr  = sel ? data.addr  : inst.addr;
  assign mem.wstrb = sel ? data.wstrb : inst.wstrb;
  assign mem.wdata = sel ? data.wdata : inst.wdata;

  assign inst.addr_ok = accept & ~sel;
  assign data.addr_ok = accept &  sel;

  // Responses with nothing outstanding are dropped (spurious, or belonging
  // to transactions discarded by reset).
  assign pop  = mem.data_ok & (count_q != '0) & ~reset;
  assign head = tag_q[rd_ptr_q];

  assign inst.data_ok = pop & ~head;
  assign data.data_ok = pop &  head;
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  // In-order tag FIFO; accept already implies not full.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      tag_q    <= '0;
    end else begin
      if (accept) begin
        tag_q[wr_ptr_q] <= sel;
        wr_ptr_q        <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      count_q <= count_q + CW'(accept) - CW'(pop);
    end
  end

`ifdef BRIDGE_RR_ARB_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last_q <= 1'b0;
    end else if (accept) begin
      rr_last_q <= sel;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_sram_bridge.sv
// tb/tb_cpu_sram_bridge.sv - self-checking bench for cpu_sram_bridge
module tb_cpu_sram_bridge;
  localparam int OUT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cpu_sram_bridge_if inst_if ();
  cpu_sram_bridge_if data_if ();
  cpu_sram_bridge_if mem_if ();

  cpu_sram_bridge #(.OUTSTANDING(OUT)) dut (
    .clk   (clk),
    .reset (reset),
    .inst  (inst_if),
    .data  (data_if),
    .mem   (mem_if)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference model: queue of outstanding sources, plus a pending
  // (presented but not accepted) request that must win the next grant.
  bit mq[$];
  bit pend_valid = 1'b0;
  bit pend_src = 1'b0;
  bit rr_last = 1'b0;
  bit m_acc_inst = 1'b0;
  bit m_acc_data = 1'b0;

  always @(negedge clk) begin : compare
    bit sel, sreq, ereq, eacc, epop, etag;
    if (reset) begin
      chk("rst_mem_req", {31'd0, mem_if.req}, 32'd0);
      chk("rst_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd0);
      chk("rst_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd0);
      chk("rst_inst_data_ok", {31'd0, inst_if.data_ok}, 32'd0);
      chk("rst_data_data_ok", {31'd0, data_if.data_ok}, 32'd0);
      mq.delete();
      pend_valid = 1'b0;
      rr_last = 1'b0;
      m_acc_inst = 1'b0;
      m_acc_data = 1'b0;
    end else begin
      if (pend_valid) sel = pend_src;
`ifdef BRIDGE_RR_ARB_EN
      else if (inst_if.req && data_if.req) sel = ~rr_last;
`endif
      else sel = data_if.req;
      sreq = sel ? data_if.req : inst_if.req;
      ereq = sreq && (mq.size() < OUT);
      eacc = ereq && mem_if.addr_ok;
      epop = mem_if.data_ok && (mq.size() > 0);
      etag = epop ? mq[0] : 1'b0;
      chk("mem_req", {31'd0, mem_if.req}, {31'd0, ereq});
      chk("inst_addr_ok", {31'd0, inst_if.addr_ok}, {31'd0, eacc && !sel});
      chk("data_addr_ok", {31'd0, data_if.addr_ok}, {31'd0, eacc && sel});
      chk("inst_data_ok", {31'd0, inst_if.data_ok}, {31'd0, epop && !etag});
      chk("data_data_ok", {31'd0, data_if.data_ok}, {31'd0, epop && etag});
      chk("inst_rdata", inst_if.rdata, mem_if.rdata);
      chk("data_rdata", data_if.rdata, mem_if.rdata);
      if (ereq) begin
        chk("mem_addr", mem_if.addr, sel ? data_if.addr : inst_if.addr);
        chk("mem_wr", {31'd0, mem_if.wr}, {31'd0, sel ? data_if.wr : inst_if.wr});
        chk("mem_size", {30'd0, mem_if.size}, {30'd0, sel ? data_if.size : inst_if.size});
        chk("mem_wstrb", {28'd0, mem_if.wstrb}, {28'd0, sel ? data_if.wstrb : inst_if.wstrb});
        chk("mem_wdata", mem_if.wdata, sel ? data_if.wdata : inst_if.wdata);
      end
      if (epop) void'(mq.pop_front());
      if (eacc) begin
        mq.push_back(sel);
        rr_last = sel;
        pend_valid = 1'b0;
      end else if (ereq) begin
        pend_valid = 1'b1;
        pend_src = sel;
      end
      m_acc_inst = eacc && !sel;
      m_acc_data = eacc && sel;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd2;
    inst_if.addr = 32'd0; inst_if.wstrb = 4'd0; inst_if.wdata = 32'd0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd2;
    data_if.addr = 32'd0; data_if.wstrb = 4'd0; data_if.wdata = 32'd0;
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = 32'd0;
  endtask

  initial begin
    idle();
    // Reset state, with every input trying to provoke activity
    inst_if.req = 1'b1; data_if.req = 1'b1;
    mem_if.addr_ok = 1'b1; mem_if.data_ok = 1'b1;
    @(negedge clk);
    chk("t0_mem_req", {31'd0, mem_if.req}, 32'd0);
    chk("t0_data_ok", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    step(); idle(); reset = 1'b0;
    step();

    // Conflict: data first, then inst; responses routed in order
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000000;
    data_if.req = 1'b1; data_if.addr = 32'h00001000;
    mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("t2_c0_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd1);
    chk("t2_c0_mem_addr", mem_if.addr, 32'h00001000);
    step();
`ifdef BRIDGE_RR_ARB_EN
    data_if.addr = 32'h00002000;
    @(negedge clk);
    chk("t2_rr_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd1);
    chk("t2_rr_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd0);
    step();
    inst_if.req = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'h11;
    @(negedge clk);
    chk("t2_rr_full", {31'd0, mem_if.req}, 32'd0);
    chk("t2_resp_data", {31'd0, data_if.data_ok}, 32'd1);
    step();
    mem_if.rdata = 32'h22;
    @(negedge clk);
    chk("t2_resp_inst", {31'd0, inst_if.data_ok}, 32'd1);
    chk("t2_rr_data_late", {31'd0, data_if.addr_ok}, 32'd1);
    chk("t2_rr_mem_addr", mem_if.addr, 32'h00002000);
    step();
    data_if.req = 1'b0; mem_if.addr_ok = 1'b0; mem_if.rdata = 32'h33;
    @(negedge clk);
    chk("t2_rr_resp3", {31'd0, data_if.data_ok}, 32'd1);
`else
    data_if.req = 1'b0;
    @(negedge clk);
    chk("t2_c1_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd1);
    chk("t2_c1_mem_addr", mem_if.addr, 32'h1c000000);
    step();
    inst_if.req = 1'b0; mem_if.addr_ok = 1'b0;
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h11;
    @(negedge clk);
    chk("t2_resp_data", {31'd0, data_if.data_ok}, 32'd1);
    chk("t2_resp_data_rdata", data_if.rdata, 32'h11);
    chk("t2_resp_not_inst", {31'd0, inst_if.data_ok}, 32'd0);
    step();
    mem_if.rdata = 32'h22;
    @(negedge clk);
    chk("t2_resp_inst", {31'd0, inst_if.data_ok}, 32'd1);
    chk("t2_resp_inst_rdata", inst_if.rdata, 32'h22);
`endif
    step(); idle();

    // Single data read
    data_if.req = 1'b1; data_if.addr = 32'h1c000100; mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("t1_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd1);
    chk("t1_mem_addr", mem_if.addr, 32'h1c000100);
    step(); idle();
    step();
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'hDEADBEEF;
    @(negedge clk);
    chk("t1_data_data_ok", {31'd0, data_if.data_ok}, 32'd1);
    chk("t1_data_rdata", data_if.rdata, 32'hDEADBEEF);
    chk("t1_inst_data_ok", {31'd0, inst_if.data_ok}, 32'd0);
    step(); idle();

    // Lock holds inst against a later data request
    inst_if.req = 1'b1; inst_if.addr = 32'h1c000000;
    @(negedge clk);
    chk("t3_c0_mem_addr", mem_if.addr, 32'h1c000000);
    step();
    data_if.req = 1'b1; data_if.addr = 32'h00003000;
    @(negedge clk);
    chk("t3_c1_mem_addr", mem_if.addr, 32'h1c000000);
    step();
    @(negedge clk);
    chk("t3_c2_mem_addr", mem_if.addr, 32'h1c000000);
    step();
    mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("t3_c3_inst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd1);
    chk("t3_c3_mem_addr", mem_if.addr, 32'h1c000000);
    step();
    inst_if.req = 1'b0;
    @(negedge clk);
    chk("t3_c4_data_addr_ok", {31'd0, data_if.addr_ok}, 32'd1);
    step(); idle();
    mem_if.data_ok = 1'b1;
    @(negedge clk);
    chk("t3_resp_inst", {31'd0, inst_if.data_ok}, 32'd1);
    step();
    @(negedge clk);
    chk("t3_resp_data", {31'd0, data_if.data_ok}, 32'd1);
    step(); idle();

    // Full blocking with OUTSTANDING=2
    inst_if.req = 1'b1; inst_if.addr = 32'h100; mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("t4_acc0", {31'd0, inst_if.addr_ok}, 32'd1);
    step(); inst_if.addr = 32'h104;
    @(negedge clk);
    chk("t4_acc1", {31'd0, inst_if.addr_ok}, 32'd1);
    step(); inst_if.addr = 32'h108;
    @(negedge clk);
    chk("t4_full_req", {31'd0, mem_if.req}, 32'd0);
    step(); mem_if.data_ok = 1'b1; mem_if.rdata = 32'h55;
    @(negedge clk);
    chk("t4_full_pop_req", {31'd0, mem_if.req}, 32'd0);
    chk("t4_pop_inst", {31'd0, inst_if.data_ok}, 32'd1);
    step(); mem_if.data_ok = 1'b0;
    @(negedge clk);
    chk("t4_after_pop_req", {31'd0, mem_if.req}, 32'd1);
    chk("t4_after_pop_acc", {31'd0, inst_if.addr_ok}, 32'd1);
    step(); inst_if.addr = 32'h10c;
    @(negedge clk);
    chk("t4_refull", {31'd0, mem_if.req}, 32'd0);
    step(); inst_if.req = 1'b0; mem_if.data_ok = 1'b1;
    @(negedge clk);
    chk("t4_drain0", {31'd0, inst_if.data_ok}, 32'd1);
    step();
    @(negedge clk);
    chk("t4_drain1", {31'd0, inst_if.data_ok}, 32'd1);
    step(); idle();

    // Spurious response leaves count at 0
    mem_if.data_ok = 1'b1;
    @(negedge clk);
    chk("t5_spur_ok", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    step(); mem_if.data_ok = 1'b0;
    data_if.req = 1'b1; data_if.addr = 32'h40; mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("t5_acc0", {31'd0, data_if.addr_ok}, 32'd1);
    step(); data_if.addr = 32'h44;
    @(negedge clk);
    chk("t5_acc1", {31'd0, data_if.addr_ok}, 32'd1);
    step(); data_if.addr = 32'h48;
    @(negedge clk);
    chk("t5_full", {31'd0, mem_if.req}, 32'd0);
    step(); data_if.req = 1'b0; mem_if.data_ok = 1'b1;
    @(negedge clk);
    chk("t5_drain0", {31'd0, data_if.data_ok}, 32'd1);
    step();
    @(negedge clk);
    chk("t5_drain1", {31'd0, data_if.data_ok}, 32'd1);
    step(); idle();

    // Reset mid-flight drops the outstanding response
    data_if.req = 1'b1; data_if.addr = 32'h80; mem_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("t6_acc", {31'd0, data_if.addr_ok}, 32'd1);
    step(); data_if.req = 1'b0; inst_if.req = 1'b1; reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_mem_req", {31'd0, mem_if.req}, 32'd0);
    chk("t6_rst_addr_ok", {31'd0, inst_if.addr_ok}, 32'd0);
    step(); reset = 1'b0; inst_if.req = 1'b0; mem_if.data_ok = 1'b1;
    @(negedge clk);
    chk("t6_dropped", {30'd0, inst_if.data_ok, data_if.data_ok}, 32'd0);
    step(); idle();

    // Randomized traffic against the model; held requests stay stable
    for (int c = 0; c < 3000; c++) begin
      step();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 299) == 0) reset = 1'b1;
      if (!(inst_if.req && !m_acc_inst)) begin
        inst_if.req   = ($urandom_range(0, 99) < 45);
        inst_if.wr    = 1'b0;
        inst_if.size  = 2'($urandom_range(0, 2));
        inst_if.addr  = $urandom;
        inst_if.wstrb = 4'($urandom);
        inst_if.wdata = $urandom;
      end
      if (!(data_if.req && !m_acc_data)) begin
        data_if.req   = ($urandom_range(0, 99) < 45);
        data_if.wr    = 1'($urandom_range(0, 1));
        data_if.size  = 2'($urandom_range(0, 2));
        data_if.addr  = $urandom;
        data_if.wstrb = 4'($urandom);
        data_if.wdata = $urandom;
      end
      mem_if.addr_ok = ($urandom_range(0, 99) < 60);
      mem_if.data_ok = ($urandom_range(0, 99) < 40);
      mem_if.rdata   = $urandom;
    end
    step(); idle(); reset = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
